// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores on a req/ack bus, stalls the
// upstream pipeline while waiting, and drives the MEM/WB register fields.
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        StallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        DAbort
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t     state, stateNext;
  logic [7:0] waitCnt;
  logic       pcSrcL, regWriteL, memtoRegL;
  logic [3:0] wa3L;
  logic       access, aligned, timeout;

  always_comb begin
    access    = MemtoRegM | MemWriteM;
    aligned   = (ALUResultM[1:0] == 2'b00);
    stateNext = state;
    StallM    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          StallM    = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (MemAck) begin
          stateNext = IDLE;
        end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
          timeout   = 1'b1;
          stateNext = IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign MemReq = (state == REQ);

  // Falling-edge stage boundary: MEM/WB register plus latched request
  always_ff @(negedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      waitCnt   <= '0;
      DAbort    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      pcSrcL    <= 1'b0;
      regWriteL <= 1'b0;
      memtoRegL <= 1'b0;
      wa3L      <= '0;
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WA3W      <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          ALUOutW <= ALUResultM;
          WA3W    <= WA3M;
          if (!access) begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= 1'b0;
          end else begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            if (!aligned) begin
              DAbort <= 1'b1;
            end else begin
              MemAddr   <= ALUResultM;
              MemWData  <= WriteDataM;
              MemWe     <= MemWriteM;
              pcSrcL    <= PCSrcM;
              regWriteL <= RegWriteM;
              memtoRegL <= MemtoRegM & ~MemWriteM;
              wa3L      <= WA3M;
              waitCnt   <= '0;
            end
          end
        end
        REQ: begin
          if (MemAck) begin
            PCSrcW    <= pcSrcL;
            RegWriteW <= regWriteL;
            MemtoRegW <= memtoRegL;
            ALUOutW   <= MemAddr;
            WA3W      <= wa3L;
            if (memtoRegL) ReadDataW <= MemRData;
          end else begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            if (timeout) DAbort <= 1'b1;
            else         waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
